// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// memory-op codes, FSM encoding, bus command payload and access-width helpers.
package mem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CODE_W = 4;

    localparam logic [CODE_W-1:0] MC_LW   = 4'b0000;
    localparam logic [CODE_W-1:0] MC_SW   = 4'b0001;
    localparam logic [CODE_W-1:0] MC_LH   = 4'b0010;
    localparam logic [CODE_W-1:0] MC_LB   = 4'b0011;
    localparam logic [CODE_W-1:0] MC_LHU  = 4'b0100;
    localparam logic [CODE_W-1:0] MC_LBU  = 4'b0101;
    localparam logic [CODE_W-1:0] MC_SH   = 4'b0110;
    localparam logic [CODE_W-1:0] MC_SB   = 4'b0111;
    localparam logic [CODE_W-1:0] MC_NONE = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } size_e;

    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_cmd_t;

    function automatic logic is_load(input logic [CODE_W-1:0] code);
        return (code == MC_LW) || (code == MC_LH) || (code == MC_LB) ||
               (code == MC_LHU) || (code == MC_LBU);
    endfunction

    function automatic logic is_store(input logic [CODE_W-1:0] code);
        return (code == MC_SW) || (code == MC_SH) || (code == MC_SB);
    endfunction

    // Unknown codes fall into SZ_NONE and are handled like MC_NONE.
    function automatic size_e access_size(input logic [CODE_W-1:0] code);
        size_e sz;
        case (code)
            MC_LW, MC_SW:          sz = SZ_WORD;
            MC_LH, MC_LHU, MC_SH:  sz = SZ_HALF;
            MC_LB, MC_LBU, MC_SB:  sz = SZ_BYTE;
            default:               sz = SZ_NONE;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input logic [CODE_W-1:0] code, input logic [1:0] lo);
        logic mis;
        case (access_size(code))
            SZ_WORD: mis = (lo != 2'b00);
            SZ_HALF: mis = lo[0];
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Word-aligned address, lane enables and lane-replicated store data.
    function automatic bus_cmd_t build_cmd(input logic [CODE_W-1:0] code,
                                           input logic [ADDR_W-1:0] addr,
                                           input logic [DATA_W-1:0] wdata);
        bus_cmd_t cmd;
        cmd.we    = is_store(code);
        cmd.addr  = {addr[ADDR_W-1:2], 2'b00};
        cmd.be    = '0;
        cmd.wdata = '0;
        case (access_size(code))
            SZ_WORD: begin
                cmd.be = 4'b1111;
                if (cmd.we) cmd.wdata = wdata;
            end
            SZ_HALF: begin
                cmd.be = addr[1] ? 4'b1100 : 4'b0011;
                if (cmd.we) cmd.wdata = {2{wdata[15:0]}};
            end
            SZ_BYTE: begin
                cmd.be = 4'b0001 << addr[1:0];
                if (cmd.we) cmd.wdata = {4{wdata[7:0]}};
            end
            default: ;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extender.sv
// Combinational load formatter: picks the byte/half lane addressed by addr_lo
// out of the bus word and sign- or zero-extends it according to mem_code.
module load_extender
    import mem_pkg::*;
(
    input  logic [DATA_W-1:0] rword,
    input  logic [1:0]        addr_lo,
    input  logic [CODE_W-1:0] mem_code,
    output logic [DATA_W-1:0] ext_c
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        byte_c = 8'(rword >> {addr_lo, 3'b000});
        half_c = addr_lo[1] ? rword[31:16] : rword[15:0];
        case (mem_code)
            MC_LW:   ext_c = rword;
            MC_LH:   ext_c = {{16{half_c[15]}}, half_c};
            MC_LHU:  ext_c = {16'h0000, half_c};
            MC_LB:   ext_c = {{24{byte_c[7]}}, byte_c};
            MC_LBU:  ext_c = {24'h000000, byte_c};
            default: ext_c = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: req/ack bus transaction with byte
// enables, load extension and pipeline stall. Optional MEM_ALIGN_EXC_EN raises
// misalignment exceptions instead of silently aligning the address.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CODE_W-1:0] mem_code,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [BE_W-1:0]   bus_be,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              bus_err,
    output logic              exc_adel,
    output logic              exc_ades
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    state_e            state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    bus_cmd_t          cmd_q, cmd_d;
    logic              req_q, req_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              adel_q, adel_d;
    logic              ades_q, ades_d;
    logic [DATA_W-1:0] ext_c;
    logic              misalign_c;

`ifdef MEM_ALIGN_EXC_EN
    assign misalign_c = is_misaligned(mem_code, addr[1:0]);
`else
    assign misalign_c = 1'b0;
`endif

    load_extender u_ext (
        .rword    (bus_rdata),
        .addr_lo  (addr_lo_q),
        .mem_code (code_q),
        .ext_c    (ext_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            code_q    <= '0;
            addr_lo_q <= '0;
            cmd_q     <= '0;
            req_q     <= 1'b0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            adel_q    <= 1'b0;
            ades_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            addr_lo_q <= addr_lo_d;
            cmd_q     <= cmd_d;
            req_q     <= req_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            adel_q    <= adel_d;
            ades_q    <= ades_d;
        end
    end

    // Next state plus next value of every registered output; entering RESP arms the done pulse.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        addr_lo_d = addr_lo_q;
        cmd_d     = cmd_q;
        req_d     = req_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        rdata_d   = rdata_q;
        err_d     = 1'b0;
        adel_d    = 1'b0;
        ades_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (access_size(mem_code) == SZ_NONE) begin
                        state_d = ST_RESP;
                        done_d  = 1'b1;
                        rdata_d = '0;
                    end else if (misalign_c) begin
                        state_d = ST_RESP;
                        done_d  = 1'b1;
                        rdata_d = '0;
                        adel_d  = is_load(mem_code);
                        ades_d  = is_store(mem_code);
                    end else begin
                        state_d   = ST_REQ;
                        code_d    = mem_code;
                        addr_lo_d = addr[1:0];
                        cmd_d     = build_cmd(mem_code, addr, wdata);
                        req_d     = 1'b1;
                        cnt_d     = '0;
                    end
                end
            end
            ST_REQ: begin
                if (bus_ack) begin
                    state_d = ST_RESP;
                    req_d   = 1'b0;
                    cmd_d   = '0;
                    done_d  = 1'b1;
                    rdata_d = ext_c;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES))) begin
                    state_d = ST_RESP;
                    req_d   = 1'b0;
                    cmd_d   = '0;
                    done_d  = 1'b1;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus_req   = req_q;
    assign bus_we    = cmd_q.we;
    assign bus_be    = cmd_q.be;
    assign bus_addr  = cmd_q.addr;
    assign bus_wdata = cmd_q.wdata;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign bus_err   = err_q;
    assign exc_adel  = adel_q;
    assign exc_ades  = ades_q;

    // Stall also covers the IDLE cycle in which a start is taken.
    assign busy = (state_q != ST_IDLE) || start;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a transaction-level model sets the expected
// per-cycle outputs, a negedge process compares them, plus literal spot checks.
module tb_mem_access_ctrl;

    localparam int TMO = 4;
`ifdef MEM_ALIGN_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  mem_code;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        bus_err;
    logic        exc_adel;
    logic        exc_ades;

    int n_checks = 0;
    int n_fail   = 0;

    logic        exp_busy, exp_req, exp_done, exp_err, exp_adel, exp_ades, exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;

    int          obs_done_cyc, obs_busy_cnt;
    logic        obs_req_seen, obs_err, obs_adel, obs_ades, obs_we;
    logic [3:0]  obs_be;
    logic [31:0] obs_addr, obs_wdata;

    mem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mem_code  (mem_code),
        .addr      (addr),
        .wdata     (wdata),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_be    (bus_be),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .bus_err   (bus_err),
        .exc_adel  (exc_adel),
        .exc_ades  (exc_ades)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endfunction

    // Model helpers: access width in bytes, naturally aligned lane offset.
    function automatic bit is_ld(input logic [3:0] c);
        return c inside {4'h0, 4'h2, 4'h3, 4'h4, 4'h5};
    endfunction

    function automatic bit is_st(input logic [3:0] c);
        return c inside {4'h1, 4'h6, 4'h7};
    endfunction

    function automatic int nbytes(input logic [3:0] c);
        case (c)
            4'h0, 4'h1:       return 4;
            4'h2, 4'h4, 4'h6: return 2;
            4'h3, 4'h5, 4'h7: return 1;
            default:          return 0;
        endcase
    endfunction

    function automatic int lane_off(input logic [3:0] c, input logic [31:0] a);
        int nb;
        nb = nbytes(c);
        if (nb == 4 || nb == 0) return 0;
        return (int'(a[1:0]) / nb) * nb;
    endfunction

    function automatic bit misaligned(input logic [3:0] c, input logic [31:0] a);
        int nb;
        nb = nbytes(c);
        return (nb > 1) && ((int'(a[1:0]) % nb) != 0);
    endfunction

    function automatic logic [3:0] model_be(input logic [3:0] c, input logic [31:0] a);
        return 4'(((1 << nbytes(c)) - 1) << lane_off(c, a));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [3:0] c, input logic [31:0] w);
        case (nbytes(c))
            1:       return {24'h0, w[7:0]} * 32'h0101_0101;
            2:       return {16'h0, w[15:0]} * 32'h0001_0001;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [3:0] c, input logic [31:0] a, input logic [31:0] w);
        int nb;
        logic [31:0] mask, v;
        nb   = nbytes(c);
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        v    = (w >> (8 * lane_off(c, a))) & mask;
        if ((c == 4'h2 || c == 4'h3) && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic observe(input int cyc);
        #1;
        if (busy) obs_busy_cnt++;
        if (done && obs_done_cyc < 0) begin
            obs_done_cyc = cyc;
            obs_err  = bus_err;
            obs_adel = exc_adel;
            obs_ades = exc_ades;
        end
        if (bus_req) begin
            obs_req_seen = 1'b1;
            obs_we    = bus_we;
            obs_be    = bus_be;
            obs_addr  = bus_addr;
            obs_wdata = bus_wdata;
        end
    endtask

    // Entered just after a rising edge; ack_delay = ack-less REQ cycles before bus_ack.
    task automatic run_txn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] w,
                           input logic [31:0] rw, input int ack_delay, input int gap);
        bit ld, st, mis, tmo;
        int nreq;
        ld   = is_ld(c);
        st   = is_st(c);
        mis  = EXC_EN && (ld || st) && misaligned(c, a);
        tmo  = (ld || st) && !mis && (ack_delay > TMO);
        nreq = (!(ld || st) || mis) ? 0 : (tmo ? TMO + 1 : ack_delay + 1);
        obs_done_cyc = -1; obs_busy_cnt = 0; obs_req_seen = 1'b0;
        obs_err = 1'b0; obs_adel = 1'b0; obs_ades = 1'b0;
        obs_we = 1'b0; obs_be = '0; obs_addr = '0; obs_wdata = '0;

        start = 1'b1; mem_code = c; addr = a; wdata = w;
        bus_ack = 1'b1; bus_rdata = ~rw;
        exp_busy = 1'b1; exp_req = 1'b0; exp_done = 1'b0;
        exp_err = 1'b0; exp_adel = 1'b0; exp_ades = 1'b0;
        observe(0);
        @(posedge clk); #1;

        // start and fresh operands while busy must be ignored
        start = 1'b1; mem_code = 4'h8; addr = ~a; wdata = ~w;
        for (int j = 0; j < nreq; j++) begin
            exp_req = 1'b1; exp_we = st;
            exp_be = model_be(c, a); exp_addr = a & 32'hFFFF_FFFC; exp_wdata = model_wdata(c, w);
            bus_ack   = (j == ack_delay);
            bus_rdata = (j == ack_delay) ? rw : ~rw;
            observe(j + 1);
            @(posedge clk); #1;
        end

        bus_ack = 1'b0;
        exp_req = 1'b0; exp_done = 1'b1; exp_err = tmo;
        exp_adel = mis && ld; exp_ades = mis && st;
        exp_rdata = (ld && !mis && !tmo) ? model_load(c, a, rw) : 32'h0;
        observe(nreq + 1);
        @(posedge clk); #1;

        start = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
        exp_err = 1'b0; exp_adel = 1'b0; exp_ades = 1'b0;
        for (int g = 0; g < gap; g++) begin
            bus_ack = 1'b1; bus_rdata = 32'h5A5A_5A5A;
            @(posedge clk); #1;
        end
        bus_ack = 1'b0;
    endtask

    always @(negedge clk) begin
        chk("busy",     32'(busy),     32'(exp_busy));
        chk("bus_req",  32'(bus_req),  32'(exp_req));
        chk("done",     32'(done),     32'(exp_done));
        chk("bus_err",  32'(bus_err),  32'(exp_err));
        chk("exc_adel", 32'(exc_adel), 32'(exp_adel));
        chk("exc_ades", 32'(exc_ades), 32'(exp_ades));
        chk("rdata",    rdata,         exp_rdata);
        if (exp_req) begin
            chk("bus_we",   32'(bus_we), 32'(exp_we));
            chk("bus_be",   32'(bus_be), 32'(exp_be));
            chk("bus_addr", bus_addr,    exp_addr);
            if (exp_we) chk("bus_wdata", bus_wdata, exp_wdata);
        end
    end

    initial begin
        reset = 1'b0; start = 1'b0; mem_code = 4'h8; addr = '0; wdata = '0;
        bus_ack = 1'b0; bus_rdata = '0;
        exp_busy = 1'b0; exp_req = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
        exp_adel = 1'b0; exp_ades = 1'b0; exp_we = 1'b0; exp_be = '0;
        exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
        #7;
        chk("rst_bus_req", 32'(bus_req), 32'h0);
        chk("rst_bus_be",  32'(bus_be),  32'h0);
        chk("rst_rdata",   rdata,        32'h0);
        #15 reset = 1'b1;
        @(posedge clk); #1;

        run_txn(4'h3, 32'h0000_0003, 32'h0, 32'h80FF_FF7F, 0, 1);
        chk("lb_be",      32'(obs_be),       32'h8);
        chk("lb_rdata",   rdata,             32'hFFFF_FF80);
        chk("lb_latency", 32'(obs_done_cyc), 32'd2);

        run_txn(4'h6, 32'h0000_0012, 32'h1234_ABCD, 32'h0, 0, 1);
        chk("sh_addr",  obs_addr,      32'h0000_0010);
        chk("sh_be",    32'(obs_be),   32'hC);
        chk("sh_wdata", obs_wdata,     32'hABCD_ABCD);
        chk("sh_we",    32'(obs_we),   32'h1);

        run_txn(4'h4, 32'h0000_0002, 32'h0, 32'hF00D_0000, 3, 1);
        chk("lhu_busy_cycles", 32'(obs_busy_cnt), 32'd6);
        chk("lhu_rdata",       rdata,             32'h0000_F00D);

        run_txn(4'h0, 32'h0000_0100, 32'h0, 32'h1111_1111, 1000, 0);
        chk("tmo_latency", 32'(obs_done_cyc), 32'd6);
        chk("tmo_err",     32'(obs_err),      32'h1);
        chk("tmo_rdata",   rdata,             32'h0);

        run_txn(4'h5, 32'h0000_0101, 32'h0, 32'h1234_5678, 0, 1);
        chk("b2b_latency", 32'(obs_done_cyc), 32'd2);
        chk("lbu_rdata",   rdata,             32'h0000_0056);

        run_txn(4'h1, 32'h0000_0006, 32'hCAFE_F00D, 32'h0, 1, 1);
`ifdef MEM_ALIGN_EXC_EN
        chk("sw_mis_ades",    32'(obs_ades),     32'h1);
        chk("sw_mis_latency", 32'(obs_done_cyc), 32'd1);
        chk("sw_mis_noreq",   32'(obs_req_seen), 32'h0);
`else
        chk("sw_mis_be",   32'(obs_be), 32'hF);
        chk("sw_mis_addr", obs_addr,    32'h0000_0004);
`endif

        run_txn(4'h2, 32'h0000_0002, 32'h0, 32'h8001_1234, 2, 1);
        chk("lh_rdata", rdata, 32'hFFFF_8001);
        run_txn(4'h0, 32'h0000_0000, 32'h0, 32'hDEAD_BEEF, 0, 0);
        run_txn(4'hB, 32'h0000_0000, 32'h0, 32'h0, 0, 1);
        chk("inv_latency", 32'(obs_done_cyc), 32'd1);
        chk("inv_rdata",   rdata,             32'h0);
        run_txn(4'h7, 32'h0000_0001, 32'h0000_00A5, 32'h0, 1, 1);
        chk("sb_wdata", obs_wdata, 32'hA5A5_A5A5);
        run_txn(4'h2, 32'h0000_0001, 32'h0, 32'h7FFF_8000, 0, 1);
        run_txn(4'h3, 32'h0000_0002, 32'h0, 32'h007F_0000, 0, 1);

        // Reset while a store is waiting in REQ.
        start = 1'b1; mem_code = 4'h1; addr = 32'h40; wdata = 32'h0BAD_F00D;
        exp_busy = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_req = 1'b1; exp_we = 1'b1; exp_be = 4'hF; exp_addr = 32'h40; exp_wdata = 32'h0BAD_F00D;
        #1;
        chk("pre_rst_req", 32'(bus_req), 32'h1);
        reset = 1'b0;
        exp_busy = 1'b0; exp_req = 1'b0; exp_rdata = 32'h0;
        #1;
        chk("mid_rst_req",  32'(bus_req), 32'h0);
        chk("mid_rst_busy", 32'(busy),    32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        run_txn(4'h8, 32'h0, 32'h0, 32'h0, 0, 2);
        chk("none_latency", 32'(obs_done_cyc), 32'd1);
        chk("none_rdata",   rdata,             32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
